// File: rtl/m_axi_lite_master.sv
// AXI4-Lite initiator. A single-beat command is turned into one AXI4-Lite
// read or write transaction, and its result comes back as one response.
// Only one transaction is in flight at a time. Every output is driven from
// registers, so no input reaches an output through logic alone.
//
// Handshake rule used on every channel here: a transfer happens on the
// rising edge where VALID and READY are both high. A source keeps VALID high,
// and its payload unchanged, until that edge. A source never waits for READY
// before raising VALID.
module m_axi_lite_master #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          BYTE_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [BYTE_WIDTH-1:0] cmd_wstrb,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // write address channel
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // write data channel
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [BYTE_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // write response channel
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // read address channel
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // current FSM state, for observation only
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q;
  logic                  aw_done_q, w_done_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTE_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;

  logic cmd_fire, aw_fire, w_fire;

  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_fire   = m_axi_wvalid & m_axi_wready;

  // State register. A reset during a transaction drops it without any response.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. AW and W may finish in either order or on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = cmd_we ? S_WRITE : S_RADDR;
      S_WRITE: if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) state_d = S_WRESP;
      S_WRESP: if (m_axi_bvalid) state_d = S_RSP;
      S_RADDR: if (m_axi_arready) state_d = S_RDATA;
      S_RDATA: if (m_axi_rvalid) state_d = S_RSP;
      S_RSP:   if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. These signals depend only on the state and the done flags.
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    case (state_q)
      S_WRITE: begin
        m_axi_awvalid = ~aw_done_q;
        m_axi_wvalid  = ~w_done_q;
      end
      S_WRESP: m_axi_bready  = 1'b1;
      S_RADDR: m_axi_arvalid = 1'b1;
      S_RDATA: m_axi_rready  = 1'b1;
      S_RSP:   rsp_valid     = 1'b1;
      default: ;
    endcase
  end

  // cmd_ready is registered, so it is low for the whole reset and becomes high on the first edge after release.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cmd_ready_q <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == S_IDLE);
    end
  end

  // Latch the command. The AXI payload is held stable until the transaction ends.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_fire && state_q == S_IDLE) begin
      we_q    <= cmd_we;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // Per-channel done flags. Each VALID drops on the cycle after its own handshake.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (cmd_fire) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == S_WRITE) begin
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
    end
  end

  // Capture the response. Writes return zero data. Error codes are passed on as received.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdata_q <= '0;
      resp_q  <= 2'b00;
    end else if (state_q == S_WRESP && m_axi_bvalid) begin
      rdata_q <= '0;
      resp_q  <= m_axi_bresp;
    end else if (state_q == S_RDATA && m_axi_rvalid) begin
      rdata_q <= m_axi_rdata;
      resp_q  <= m_axi_rresp;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_we       = we_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_m_axi_lite_master.sv
// Bench for m_axi_lite_master. A reactive AXI4-Lite slave memory has
// programmable per-channel stall counts. The bench runs a directed vector
// table, two hand-written multi-cycle sequences, and then random traffic.
// A reference memory and the protocol timing rules give the expected results.
module tb_m_axi_lite_master;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready;
  logic        rsp_valid, rsp_we;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = '0;
  logic [2:0]  dbg_state;

  m_axi_lite_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // ---------------- slave model ----------------
  int cfg_da = 0, cfg_dw = 0, cfg_db = 0, cfg_dar = 0, cfg_dr = 0;
  logic [1:0] cfg_resp = 2'b00;
  int aw_fires = 0, w_fires = 0, b_fires = 0, ar_fires = 0, r_fires = 0;
  logic [31:0] slv_mem [logic [29:0]];

  bit aw_got = 0, w_got = 0, ar_got = 0, p_bfire = 0, p_rfire = 0, p_rstn = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0, p_arvalid = 0, p_arready = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;

  // Slave outputs change on the falling edge. The master's outputs are already settled then.
  always @(negedge aclk) begin
    if (!aresetn) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0; p_bfire = 0; p_rfire = 0; p_rstn = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_arvalid = 0; p_arready = 0;
    end else begin
      // protocol monitor, looking across the rising edge just passed
      if (p_rstn) begin
        if (p_awvalid && !p_awready) chk("awvalid_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
        if (p_awvalid && p_awready)  chk("awvalid_drop", m_axi_awvalid, 1'b0);
        if (p_wvalid && !p_wready)   chk("wvalid_hold", {m_axi_wvalid, m_axi_wstrb, m_axi_wdata}, {1'b1, p_wstrb, p_wdata});
        if (p_wvalid && p_wready)    chk("wvalid_drop", m_axi_wvalid, 1'b0);
        if (p_arvalid && !p_arready) chk("arvalid_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});
        if (p_arvalid && p_arready)  chk("arvalid_drop", m_axi_arvalid, 1'b0);
        if (m_axi_bready)            chk("bready_only_after_aw_w", {aw_got, w_got}, 2'b11);
        if (m_axi_rready)            chk("rready_only_after_ar", ar_got, 1'b1);
      end
      // write response
      if (p_bfire) begin
        m_axi_bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0;
      end else if (aw_got && w_got && !m_axi_bvalid) begin
        if (b_cnt >= cfg_db) begin
          m_axi_bvalid = 1; m_axi_bresp = cfg_resp;
          slv_mem[cap_awaddr[31:2]] = merge(slv_mem.exists(cap_awaddr[31:2]) ? slv_mem[cap_awaddr[31:2]] : 32'h0,
                                            cap_wdata, cap_wstrb);
        end else b_cnt++;
      end
      // read data
      if (p_rfire) begin
        m_axi_rvalid = 0; ar_got = 0; r_cnt = 0; m_axi_rdata = $urandom;
      end else if (ar_got && !m_axi_rvalid) begin
        if (r_cnt >= cfg_dr) begin
          m_axi_rvalid = 1; m_axi_rresp = cfg_resp;
          m_axi_rdata = slv_mem.exists(cap_araddr[31:2]) ? slv_mem[cap_araddr[31:2]] : 32'h0;
        end else r_cnt++;
      end
      // address/data readies with stall counts
      if (m_axi_awvalid) begin
        if (aw_cnt >= cfg_da) m_axi_awready = 1; else begin m_axi_awready = 0; aw_cnt++; end
      end else begin m_axi_awready = 0; aw_cnt = 0; end
      if (m_axi_wvalid) begin
        if (w_cnt >= cfg_dw) m_axi_wready = 1; else begin m_axi_wready = 0; w_cnt++; end
      end else begin m_axi_wready = 0; w_cnt = 0; end
      if (m_axi_arvalid) begin
        if (ar_cnt >= cfg_dar) m_axi_arready = 1; else begin m_axi_arready = 0; ar_cnt++; end
      end else begin m_axi_arready = 0; ar_cnt = 0; end
      // transfers that will happen on the coming rising edge
      if (m_axi_awvalid && m_axi_awready) begin aw_got = 1; cap_awaddr = m_axi_awaddr; aw_fires++; end
      if (m_axi_wvalid && m_axi_wready) begin w_got = 1; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; w_fires++; end
      if (m_axi_arvalid && m_axi_arready) begin ar_got = 1; cap_araddr = m_axi_araddr; ar_fires++; end
      p_bfire = m_axi_bvalid && m_axi_bready;
      p_rfire = m_axi_rvalid && m_axi_rready;
      if (p_bfire) b_fires++;
      if (p_rfire) r_fires++;
      p_awvalid = m_axi_awvalid; p_awready = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wvalid = m_axi_wvalid; p_wready = m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_arvalid = m_axi_arvalid; p_arready = m_axi_arready; p_araddr = m_axi_araddr;
      p_rstn = 1;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          da, dw, db, dar, dr;
    logic [1:0]  resp;
    int          hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  logic [31:0] ref_mem [logic [29:0]];

  // driver: issue one command, collect its response, and check the per-transaction rules
  task automatic run_vec(input vec_t v, input string tag, output logic [31:0] rdata,
                         output logic [1:0] resp, output logic rwe, output int lat);
    int  cyc;
    bit  seen;
    bit  stable;
    cfg_da = v.da; cfg_dw = v.dw; cfg_db = v.db; cfg_dar = v.dar; cfg_dr = v.dr; cfg_resp = v.resp;
    aw_fires = 0; w_fires = 0; b_fires = 0; ar_fires = 0; r_fires = 0;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin @(posedge aclk); #1; cyc++; end
    chk({tag, "_cmd_ready_before"}, cmd_ready, 1'b1);
    cmd_valid = 1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    @(posedge aclk); #1;
    cmd_valid = 0; cmd_we = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = $urandom;
    chk({tag, "_cmd_ready_busy"}, cmd_ready, 1'b0);
    if (v.we) begin
      chk({tag, "_c1_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b110);
      chk({tag, "_c1_awaddr"}, m_axi_awaddr, v.addr);
      chk({tag, "_c1_wdata_wstrb"}, {m_axi_wdata, m_axi_wstrb}, {v.wdata, v.wstrb});
    end else begin
      chk({tag, "_c1_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b001);
      chk({tag, "_c1_araddr"}, m_axi_araddr, v.addr);
    end
    cyc = 1; seen = 0;
    while (cyc < 200) begin
      if (rsp_valid) begin seen = 1; break; end
      @(posedge aclk); #1; cyc++;
    end
    chk({tag, "_rsp_seen"}, seen, 1'b1);
    lat = cyc; rdata = rsp_rdata; resp = rsp_resp; rwe = rsp_we;
    if (seen && v.hold > 0) begin
      stable = 1;
      repeat (v.hold) begin
        @(posedge aclk); #1;
        if (!rsp_valid || rsp_rdata !== rdata || rsp_resp !== resp || rsp_we !== rwe || cmd_ready ||
            m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || m_axi_bready || m_axi_rready) stable = 0;
      end
      chk({tag, "_rsp_hold_stable"}, stable, 1'b1);
    end
    rsp_ready = 1;
    @(posedge aclk); #1;
    rsp_ready = 0;
    chk({tag, "_after_rsp"}, {rsp_valid, cmd_ready}, 2'b01);
    chk({tag, "_hs_counts"}, (aw_fires << 16) | (w_fires << 12) | (b_fires << 8) | (ar_fires << 4) | r_fires,
        v.we ? 32'h11100 : 32'h00011);
  endtask

  vec_t        vt[12];
  vec_t        rv;
  logic [31:0] g_rdata;
  logic [1:0]  g_resp;
  logic        g_we;
  int          g_lat;
  int          mx;
  bit          quiet;

  initial begin
    //          we  addr    wdata         strb  da dw db dar dr resp hold exp_rdata     exp_resp lat
    vt[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 3};
    vt[1]  = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'hDEADBEEF, 2'b00, 3};
    vt[2]  = '{1'b1, 32'h20, 32'h11223344, 4'hF, 0, 5, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 8};
    vt[3]  = '{1'b1, 32'h24, 32'h55667788, 4'hF, 5, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 8};
    vt[4]  = '{1'b1, 32'h28, 32'hA5A5A5A5, 4'hF, 3, 3, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 6};
    vt[5]  = '{1'b1, 32'h2C, 32'h0,        4'hF, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0,        2'b10, 3};
    vt[6]  = '{1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 2, 1, 2'b11, 0, 32'h11223344, 2'b11, 6};
    vt[7]  = '{1'b1, 32'h10, 32'hCAFE0000, 4'hC, 0, 0, 2, 0, 0, 2'b00, 0, 32'h0,        2'b00, 5};
    vt[8]  = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 10, 32'hCAFEBEEF, 2'b00, 3};
    vt[9]  = '{1'b0, 32'h24, 32'h0,        4'h0, 0, 0, 0, 0, 4, 2'b00, 0, 32'h55667788, 2'b00, 7};
    vt[10] = '{1'b1, 32'h30, 32'h0BADF00D, 4'hF, 1, 2, 1, 0, 0, 2'b00, 0, 32'h0,        2'b00, 6};
    vt[11] = '{1'b0, 32'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0BADF00D, 2'b00, 3};

    // reset: hold for a few edges, then check every output
    aresetn = 0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_valids", {rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 6'b0);
    chk("reset_rsp_fields", {rsp_rdata, rsp_resp, rsp_we}, 35'b0);
    chk("reset_axi_payload", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 68'b0);
    chk("reset_araddr", m_axi_araddr, 32'h0);
    chk("prot_constant", {m_axi_awprot, m_axi_arprot}, 6'b0);
    aresetn = 1;
    @(posedge aclk); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);

    // directed table
    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i), g_rdata, g_resp, g_we, g_lat);
      chk($sformatf("vec%0d_rdata", i), g_rdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d_resp", i), g_resp, vt[i].exp_resp);
      chk($sformatf("vec%0d_we", i), g_we, vt[i].we);
      chk($sformatf("vec%0d_latency", i), g_lat, vt[i].exp_lat);
      if (vt[i].we)
        ref_mem[vt[i].addr[31:2]] = merge(ref_mem.exists(vt[i].addr[31:2]) ? ref_mem[vt[i].addr[31:2]] : 32'h0,
                                          vt[i].wdata, vt[i].wstrb);
    end

    // reset while a stalled write is in progress: the write is abandoned without a response
    cfg_da = 40; cfg_dw = 40; cfg_db = 0;
    aw_fires = 0; w_fires = 0;
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h38; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    @(posedge aclk); #1;
    cmd_valid = 0;
    @(posedge aclk); #1;
    chk("midrst_awvalid_before", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    aresetn = 0;
    @(posedge aclk); #1;
    chk("midrst_outputs_zero", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready}, 7'b0);
    chk("midrst_awaddr_zero", m_axi_awaddr, 32'h0);
    aresetn = 1;
    @(posedge aclk); #1;
    chk("midrst_cmd_ready_after", cmd_ready, 1'b1);
    quiet = 1;
    repeat (6) begin
      @(posedge aclk); #1;
      if (rsp_valid || m_axi_awvalid || m_axi_wvalid) quiet = 0;
    end
    chk("midrst_no_response", quiet, 1'b1);
    chk("midrst_no_transfer", aw_fires + w_fires, 0);

    // random traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      rv.we    = $urandom_range(0, 1);
      rv.addr  = $urandom_range(0, 15) * 4;
      rv.wdata = $urandom;
      rv.wstrb = $urandom_range(0, 15);
      rv.da    = $urandom_range(0, 4);
      rv.dw    = $urandom_range(0, 4);
      rv.db    = $urandom_range(0, 3);
      rv.dar   = $urandom_range(0, 4);
      rv.dr    = $urandom_range(0, 3);
      rv.resp  = $urandom_range(0, 3);
      rv.hold  = $urandom_range(0, 3);
      rv.exp_resp = rv.resp;
      mx = (rv.da > rv.dw) ? rv.da : rv.dw;
      if (rv.we) begin
        rv.exp_lat = 3 + mx + rv.db;
        exp_q.push_back(32'h0);
        ref_mem[rv.addr[31:2]] = merge(ref_mem.exists(rv.addr[31:2]) ? ref_mem[rv.addr[31:2]] : 32'h0,
                                       rv.wdata, rv.wstrb);
      end else begin
        rv.exp_lat = 3 + rv.dar + rv.dr;
        exp_q.push_back(ref_mem.exists(rv.addr[31:2]) ? ref_mem[rv.addr[31:2]] : 32'h0);
      end
      run_vec(rv, $sformatf("rnd%0d", n), g_rdata, g_resp, g_we, g_lat);
      chk($sformatf("rnd%0d_rdata", n), g_rdata, exp_q.pop_front());
      chk($sformatf("rnd%0d_resp", n), g_resp, rv.exp_resp);
      chk($sformatf("rnd%0d_we", n), g_we, rv.we);
      chk($sformatf("rnd%0d_latency", n), g_lat, rv.exp_lat);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
